// File: rtl/fb_pkg.sv
// Shared constants, state encoding and address helpers for the framebuffer pixel writer.
package fb_pkg;
   localparam int SCREEN_W  = 320;
   localparam int SCREEN_H  = 240;
   localparam int FB_ADDR_W = 17;
   localparam int COLOR_W   = 12;
   localparam int X_W       = 9;
   localparam int Y_W       = 8;
   localparam int PIX_W     = X_W + Y_W + COLOR_W;

   localparam logic [FB_ADDR_W-1:0] CLEAR_LAST = FB_ADDR_W'(SCREEN_W * SCREEN_H - 1);
   localparam logic [X_W-1:0]       X_LIMIT    = X_W'(SCREEN_W);
   localparam logic [Y_W-1:0]       Y_LIMIT    = Y_W'(SCREEN_H);

   typedef enum logic [1:0] {
      S_STREAM     = 2'd0,
      S_CLEAR      = 2'd1,
      S_CLEAR_DONE = 2'd2
   } state_t;

   // y*320 + x as two shifts and an add, truncated to the RAM address width
   function automatic logic [FB_ADDR_W-1:0] xy_to_addr(input logic [X_W-1:0] x,
                                                       input logic [Y_W-1:0] y);
      logic [FB_ADDR_W-1:0] w_y;
      w_y = FB_ADDR_W'(y);
      return (w_y << 8) + (w_y << 6) + FB_ADDR_W'(x);
   endfunction

   function automatic logic xy_on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      return (x < X_LIMIT) && (y < Y_LIMIT);
   endfunction
endpackage

// File: rtl/fb_pixel_writer_if.sv
// Pixel-stream, clear-control and video-RAM write signals of the pixel writer.
// Stream and RAM writes both transfer on a cycle where valid/strobe and ready are high together;
// the producer holds its payload stable until that cycle and never retracts a raised valid.
interface fb_pixel_writer_if;
   import fb_pkg::*;

   logic                 in_valid;
   logic [X_W-1:0]       in_x;
   logic [Y_W-1:0]       in_y;
   logic [COLOR_W-1:0]   in_color;
   logic                 in_ready;
   logic                 clear_req;
   logic [COLOR_W-1:0]   clear_color;
   logic                 clear_done;
   logic                 mem_ready;
   logic                 mem_we;
   logic [FB_ADDR_W-1:0] mem_addr;
   logic [COLOR_W-1:0]   mem_data;
   logic                 busy;

   modport master (
      output in_valid, in_x, in_y, in_color, clear_req, clear_color, mem_ready,
      input  in_ready, clear_done, mem_we, mem_addr, mem_data, busy
   );

   modport slave (
      input  in_valid, in_x, in_y, in_color, clear_req, clear_color, mem_ready,
      output in_ready, clear_done, mem_we, mem_addr, mem_data, busy
   );
endinterface

// File: rtl/fb_pixel_fifo.sv
// Synchronous FIFO for pixel beats; combinational read of the head entry.
module fb_pixel_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 29
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_count;

   always_ff @(posedge clock) begin
      if (i_push) r_mem[r_wr] <= i_data;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + AW'(1);
         if (i_pop)  r_rd <= r_rd + AW'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd];
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
endmodule

// File: rtl/fb_pixel_writer.sv
// Buffers drawer pixel beats into framebuffer writes and runs the full-screen clear.
// Build option FB_CLIP_EN: off-screen beats are accepted but dropped instead of written.
module fb_pixel_writer
   import fb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clock,
   input  logic              resetn,
   fb_pixel_writer_if.slave  bus,
   output state_t            o_dbg_state
);
   state_t               r_state;
   state_t               w_next;
   logic                 r_live;
   logic                 r_clr_pend;
   logic [COLOR_W-1:0]   r_clr_color;
   logic [FB_ADDR_W-1:0] r_clr_cnt;
   logic                 r_out_valid;
   logic [FB_ADDR_W-1:0] r_addr;
   logic [COLOR_W-1:0]   r_data;

   logic                 w_in_ready;
   logic                 w_push;
   logic                 w_out_free;
   logic                 w_bypass;
   logic                 w_push_fifo;
   logic                 w_pop_fifo;
   logic                 w_load;
   logic                 w_keep;
   logic                 w_clear_start;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic [PIX_W-1:0]     w_beat;
   logic [PIX_W-1:0]     w_fifo_dout;
   logic [PIX_W-1:0]     w_src;
   logic [X_W-1:0]       w_src_x;
   logic [Y_W-1:0]       w_src_y;
   logic [COLOR_W-1:0]   w_src_c;

   assign w_in_ready = r_live && !w_fifo_full && (r_state == S_STREAM) && !r_clr_pend;
   assign w_push     = bus.in_valid && w_in_ready;
   assign w_out_free = !r_out_valid || bus.mem_ready;
   assign w_beat     = {bus.in_x, bus.in_y, bus.in_color};

   // An empty FIFO lets a fresh beat go straight to the output register for 1-cycle latency
   assign w_bypass    = w_push && w_fifo_empty && w_out_free;
   assign w_push_fifo = w_push && !w_bypass;
   assign w_pop_fifo  = (r_state == S_STREAM) && !w_fifo_empty && w_out_free;
   assign w_load      = w_pop_fifo || w_bypass;

   assign w_src   = w_fifo_empty ? w_beat : w_fifo_dout;
   assign w_src_x = w_src[PIX_W-1 -: X_W];
   assign w_src_y = w_src[COLOR_W +: Y_W];
   assign w_src_c = w_src[COLOR_W-1:0];

`ifdef FB_CLIP_EN
   assign w_keep = xy_on_screen(w_src_x, w_src_y);
`else
   assign w_keep = 1'b1;
`endif

   assign w_clear_start = bus.clear_req && r_live && (r_state == S_STREAM) && !r_clr_pend;

   fb_pixel_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PIX_W)
   ) u_fifo (
      .clock   (clock),
      .resetn  (resetn),
      .i_push  (w_push_fifo),
      .i_pop   (w_pop_fifo),
      .i_data  (w_beat),
      .o_data  (w_fifo_dout),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_state <= S_STREAM;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next          = r_state;
      bus.clear_done  = 1'b0;
      bus.mem_we      = r_out_valid;
      bus.mem_addr    = r_addr;
      bus.mem_data    = r_data;
      case (r_state)
         S_STREAM: begin
            // The clear waits until every buffered beat has been written
            if (r_clr_pend && w_fifo_empty && !r_out_valid) w_next = S_CLEAR;
         end
         S_CLEAR: begin
            bus.mem_we   = 1'b1;
            bus.mem_addr = r_clr_cnt;
            bus.mem_data = r_clr_color;
            if (bus.mem_ready && (r_clr_cnt == CLEAR_LAST)) w_next = S_CLEAR_DONE;
         end
         S_CLEAR_DONE: begin
            bus.clear_done = 1'b1;
            w_next         = S_STREAM;
         end
         default: w_next = S_STREAM;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_live      <= 1'b0;
         r_clr_pend  <= 1'b0;
         r_clr_color <= '0;
         r_clr_cnt   <= '0;
         r_out_valid <= 1'b0;
         r_addr      <= '0;
         r_data      <= '0;
      end else begin
         r_live <= 1'b1;

         if (w_clear_start) begin
            r_clr_pend  <= 1'b1;
            r_clr_color <= bus.clear_color;
         end else if (w_next == S_CLEAR) begin
            r_clr_pend  <= 1'b0;
         end

         if (r_state != S_CLEAR)  r_clr_cnt <= '0;
         else if (bus.mem_ready)  r_clr_cnt <= r_clr_cnt + FB_ADDR_W'(1);

         if (w_load) begin
            r_out_valid <= w_keep;
            r_addr      <= xy_to_addr(w_src_x, w_src_y);
            r_data      <= w_src_c;
         end else if (bus.mem_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready = w_in_ready;
   assign bus.busy     = !w_fifo_empty || r_out_valid || (r_state != S_STREAM) || r_clr_pend;
   assign o_dbg_state  = r_state;
endmodule
